// File: rtl/mul64_seq.sv
// Iterative shift-add multiplier: one partial-product accumulation per cycle,
// full 2*WIDTH-bit product after a fixed WIDTH+1 cycles, start/busy/done handshake.
module mul64_seq #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_lo,
  output logic [WIDTH-1:0] product_hi
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_d;
  logic             load_c;
  logic             step_c;
  logic             fin_c;

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [CW-1:0]      count;
  logic               neg;

  logic [WIDTH-1:0]   a_mag_c;
  logic [WIDTH-1:0]   b_mag_c;
  logic [WIDTH:0]     sum_c;
  logic [2*WIDTH-1:0] acc_full_c;
  logic [2*WIDTH-1:0] prod_c;

  // Operand magnitudes; -2^(W-1) maps to 2^(W-1), which still fits unsigned.
  assign a_mag_c = (is_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
  assign b_mag_c = (is_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;

  // Partial-product add into the upper half, keeping the carry-out.
  assign sum_c = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : {(WIDTH + 1){1'b0}});

  assign acc_full_c = {acc_hi, acc_lo};
  assign prod_c     = neg ? (~acc_full_c + (2 * WIDTH)'(1)) : acc_full_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    load_c  = 1'b0;
    step_c  = 1'b0;
    fin_c   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load_c  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step_c = 1'b1;
        if (count == CW'(1)) begin
          state_d = FIN;
        end
      end
      FIN: begin
        fin_c   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs; the multiplier shifts out of acc_lo as the product shifts in.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand      <= '0;
      acc_hi     <= '0;
      acc_lo     <= '0;
      count      <= '0;
      neg        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      product_lo <= '0;
      product_hi <= '0;
    end else begin
      done <= 1'b0;
      if (load_c) begin
        mcand  <= a_mag_c;
        acc_hi <= '0;
        acc_lo <= b_mag_c;
        count  <= CW'(WIDTH);
        neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
        busy   <= 1'b1;
      end
      if (step_c) begin
        acc_hi <= sum_c[WIDTH:1];
        acc_lo <= {sum_c[0], acc_lo[WIDTH-1:1]};
        count  <= count - CW'(1);
      end
      if (fin_c) begin
        product_hi <= prod_c[2*WIDTH-1:WIDTH];
        product_lo <= prod_c[WIDTH-1:0];
        done       <= 1'b1;
        busy       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mul64_seq.sv
// Directed self-checking bench for mul64_seq: products, latency, handshake and reset abort.
module tb_mul64_seq;

  localparam int unsigned W = 64;
  localparam int unsigned LAT = 65;
  localparam int unsigned TIMEOUT = 200;

  logic         clk;
  logic         rst;
  logic         start;
  logic         is_signed;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] product_lo;
  logic [W-1:0] product_hi;

  int n_checks = 0;
  int n_fail   = 0;

  mul64_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .is_signed  (is_signed),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .product_lo (product_lo),
    .product_hi (product_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operation; returns just after the accepting edge.
  task automatic issue(input logic sg, input logic [W-1:0] av, input logic [W-1:0] bv);
    start     = 1'b1;
    is_signed = sg;
    a         = av;
    b         = bv;
    tick();
    start = 1'b0;
    a     = '0;
    b     = '0;
  endtask

  task automatic wait_done(output int lat, output int busy_cnt);
    lat      = 0;
    busy_cnt = 0;
    while (!done && lat < TIMEOUT) begin
      if (busy) busy_cnt++;
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic sg, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic [W-1:0] exp_hi,
                        input logic [W-1:0] exp_lo);
    int lat;
    int bc;
    issue(sg, av, bv);
    check({tag, " busy_after_start"}, W'(busy), W'(1));
    wait_done(lat, bc);
    check({tag, " latency"}, W'(lat), W'(LAT));
    check({tag, " busy_cycles"}, W'(bc), W'(LAT));
    check({tag, " hi"}, product_hi, exp_hi);
    check({tag, " lo"}, product_lo, exp_lo);
    check({tag, " busy_at_done"}, W'(busy), W'(0));
    tick();
    check({tag, " done_one_cycle"}, W'(done), W'(0));
  endtask

  initial begin
    int lat;
    int bc;
    int dones;
    rst       = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    a         = '0;
    b         = '0;
    tick();
    tick();
    check("reset busy", W'(busy), W'(0));
    check("reset done", W'(done), W'(0));
    check("reset lo", product_lo, '0);
    check("reset hi", product_hi, '0);
    rst = 1'b0;
    tick();

    // Basic products, unsigned and signed
    run_op("u3x5", 1'b0, 64'd3, 64'd5, 64'h0, 64'h000000000000000F);
    run_op("umax", 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF,
           64'hFFFFFFFFFFFFFFFE, 64'h0000000000000001);
    run_op("s-1x7", 1'b1, 64'hFFFFFFFFFFFFFFFF, 64'd7,
           64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFF9);
    run_op("u(2^64-1)x7", 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'd7,
           64'h0000000000000006, 64'hFFFFFFFFFFFFFFF9);
    run_op("sminxmin", 1'b1, 64'h8000000000000000, 64'h8000000000000000,
           64'h4000000000000000, 64'h0);
    run_op("s-3x5", 1'b1, 64'hFFFFFFFFFFFFFFFD, 64'd5,
           64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFF1);
    run_op("s-3x-5", 1'b1, 64'hFFFFFFFFFFFFFFFD, 64'hFFFFFFFFFFFFFFFB, 64'h0, 64'd15);

    // Starts while busy are ignored
    issue(1'b0, 64'd2, 64'd2);
    lat = 0;
    while (!done && lat < TIMEOUT) begin
      if (lat == 10 || lat == 40) begin
        start = 1'b1;
        a     = 64'd9;
        b     = 64'd9;
      end else begin
        start = 1'b0;
      end
      tick();
      lat++;
    end
    start = 1'b0;
    check("hs latency", W'(lat), W'(LAT));
    check("hs lo", product_lo, 64'd4);
    check("hs hi", product_hi, 64'd0);

    // Start in the done cycle is accepted with no bubble
    start = 1'b1;
    a     = 64'd6;
    b     = 64'd7;
    tick();
    start = 1'b0;
    check("b2b busy", W'(busy), W'(1));
    check("b2b done_cleared", W'(done), W'(0));
    lat = 0;
    while (!done && lat < TIMEOUT) begin
      if (lat == 30) check("b2b hold_lo", product_lo, 64'd4);
      tick();
      lat++;
    end
    check("b2b latency", W'(lat), W'(LAT));
    check("b2b lo", product_lo, 64'd42);
    check("b2b hi", product_hi, 64'd0);
    dones = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (done) dones++;
    end
    check("b2b no_extra_done", W'(dones), W'(0));
    check("b2b idle_busy", W'(busy), W'(0));

    // Reset mid-operation abandons the operation
    issue(1'b0, 64'd5, 64'd5);
    repeat (29) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst busy", W'(busy), W'(0));
    check("rst done", W'(done), W'(0));
    check("rst lo", product_lo, '0);
    check("rst hi", product_hi, '0);
    dones = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (done || busy) dones++;
    end
    check("rst no_done", W'(dones), W'(0));
    run_op("after_rst 4x4", 1'b0, 64'd4, 64'd4, 64'd0, 64'd16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
